// File: rtl/systolic_pkg.sv
// +----------------------------------------------------------------------+
// | systolic_pkg: shared FSM state types and skew helper for the         |
// | ping-pong input controller.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package systolic_pkg;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_e;

  // Row offset into the bank; wraps huge when t < row so one compare against len gates the row.
  function automatic int unsigned skew_offset(input int unsigned t, input int unsigned row);
    return t - row;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_row_gen.sv
// +----------------------------------------------------------------------+
// | skew_row_gen: read enable and address for one systolic row, delayed  |
// | by the row index.                                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module skew_row_gen
  import systolic_pkg::*;
#(
  parameter int unsigned ROW = 0,
  parameter int unsigned AW  = 8,
  parameter int unsigned TW  = 10
) (
  input  logic          i_active,
  input  logic          i_bank,
  input  logic [TW-1:0] i_t,
  input  logic [AW:0]   i_len,
  output logic          o_rd_en,
  output logic [AW:0]   o_rd_addr
);

  logic [31:0] w_off;
  logic [31:0] w_len32;
  logic        w_hit;

  assign w_off     = skew_offset(32'(i_t), ROW);
  assign w_len32   = 32'(i_len);
  assign w_hit     = i_active && (w_off < w_len32);
  assign o_rd_en   = w_hit;
  assign o_rd_addr = w_hit ? {i_bank, AW'(w_off)} : '0;

endmodule

`default_nettype wire

// File: rtl/pingpong_input_ctrl.sv
// +----------------------------------------------------------------------+
// | pingpong_input_ctrl: two-bank ping-pong buffer controller; fills one |
// | bank with row beats while draining the other with a systolic skew.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pingpong_input_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned SYS_ROW = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AW:0]               num_row,
  input  logic                      wr_valid_in,
  output logic                      wr_ready,
  output logic [SYS_ROW-1:0]        wr_en,
  output logic [SYS_ROW-1:0][AW:0]  wr_addr,
  output logic                      wr_done,
  input  logic                      rd_start,
  output logic [SYS_ROW-1:0]        rd_en,
  output logic [SYS_ROW-1:0][AW:0]  rd_addr,
  output logic                      rd_busy,
  output logic                      rd_done,
  output logic [1:0]                bank_full
);

  localparam int unsigned c_tw      = $clog2(DEPTH + SYS_ROW) + 1;
  localparam logic [AW:0] c_len_max = (AW+1)'(DEPTH);

  wr_state_e         r_wstate, w_wstate_nxt;
  rd_state_e         r_rstate, w_rstate_nxt;
  logic              r_wbank, r_rbank;
  logic [AW-1:0]     r_wptr;
  logic [c_tw-1:0]   r_t;
  logic [AW:0]       r_len [2];
  logic [1:0]        r_full;
  logic              r_wr_done;

  logic [AW:0]       w_len_clamp;
  logic [AW:0]       w_wlen;
  logic [AW:0]       w_rd_len;
  logic              w_accept;
  logic              w_wlast;
  logic              w_rd_last;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  // ---------------- write side ----------------
  assign w_len_clamp = (32'(num_row) > DEPTH) ? c_len_max : num_row;
  assign wr_ready    = ~r_full[r_wbank];
  // Gating with rstn keeps the write strobe low while reset is held.
  assign w_accept    = rstn && wr_valid_in && wr_ready &&
                       ((r_wstate == W_FILL) || (num_row != '0));
  assign w_wlen      = (r_wstate == W_IDLE) ? w_len_clamp : r_len[r_wbank];
  assign w_wlast     = w_accept && ({1'b0, r_wptr} == (w_wlen - (AW+1)'(1)));

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_accept && !w_wlast) w_wstate_nxt = W_FILL;
      W_FILL:  if (w_wlast) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate  <= W_IDLE;
      r_wbank   <= 1'b0;
      r_wptr    <= '0;
      r_wr_done <= 1'b0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_wr_done <= w_wlast;
      if (w_accept) begin
        if (r_wstate == W_IDLE) r_len[r_wbank] <= w_len_clamp;
        r_wptr <= w_wlast ? '0 : r_wptr + AW'(1);
        if (w_wlast) r_wbank <= ~r_wbank;
      end
    end
  end

  assign wr_en   = {SYS_ROW{w_accept}};
  assign wr_done = r_wr_done;

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_wr_addr
    assign wr_addr[r] = w_accept ? {r_wbank, r_wptr} : '0;
  end

  // ---------------- read side ----------------
  assign w_rd_len  = r_len[r_rbank];
  assign w_rd_last = (r_rstate == R_RUN) &&
                     (32'(r_t) == (32'(w_rd_len) + SYS_ROW - 32'd2));

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (rd_start && r_full[r_rbank]) w_rstate_nxt = R_RUN;
      R_RUN:   if (w_rd_last) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate <= R_IDLE;
      r_rbank  <= 1'b0;
      r_t      <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (r_rstate == R_IDLE) begin
        r_t <= '0;
      end else if (w_rd_last) begin
        r_t     <= '0;
        r_rbank <= ~r_rbank;
      end else begin
        r_t <= r_t + c_tw'(1);
      end
    end
  end

  assign rd_busy = (r_rstate == R_RUN);
  assign rd_done = w_rd_last;

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    skew_row_gen #(
      .ROW (r),
      .AW  (AW),
      .TW  (c_tw)
    ) u_skew (
      .i_active  (rd_busy),
      .i_bank    (r_rbank),
      .i_t       (r_t),
      .i_len     (w_rd_len),
      .o_rd_en   (rd_en[r]),
      .o_rd_addr (rd_addr[r])
    );
  end

  // ---------------- bank full flags ----------------
  // Set and clear never hit the same bank: set needs it empty, clear needs it full.
  assign w_set = {w_wlast && r_wbank, w_wlast && !r_wbank};
  assign w_clr = {w_rd_last && r_rbank, w_rd_last && !r_rbank};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  assign bank_full = r_full;

endmodule

`default_nettype wire

// File: tb/tb_pingpong_input_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pingpong_input_ctrl: directed self-checking bench for the         |
// | ping-pong input controller.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pingpong_input_ctrl;

  logic              clk = 1'b0;
  logic              rstn;
  logic [8:0]        num_row;
  logic              wr_valid_in;
  logic              wr_ready;
  logic [15:0]       wr_en;
  logic [15:0][8:0]  wr_addr;
  logic              wr_done;
  logic              rd_start;
  logic [15:0]       rd_en;
  logic [15:0][8:0]  rd_addr;
  logic              rd_busy;
  logic              rd_done;
  logic [1:0]        bank_full;

  int n_checks = 0;
  int n_errors = 0;

  pingpong_input_ctrl #(
    .SYS_ROW (16),
    .DEPTH   (256)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .num_row     (num_row),
    .wr_valid_in (wr_valid_in),
    .wr_ready    (wr_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_done     (wr_done),
    .rd_start    (rd_start),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .rd_done     (rd_done),
    .bank_full   (bank_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rstn        = 1'b0;
    wr_valid_in = 1'b0;
    rd_start    = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b1;
    num_row     = '0;
    wr_valid_in = 1'b0;
    rd_start    = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_wr_done", wr_done, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Fill bank 0 with 8 rows
    num_row     = 9'd8;
    wr_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("f8_ready", wr_ready, 1);
      check("f8_wr_en", wr_en, 32'hffff);
      check("f8_addr0", wr_addr[0], i);
      check("f8_addr15", wr_addr[15], i);
      check("f8_done_lo", wr_done, 0);
      tick();
    end
    wr_valid_in = 1'b0;
    settle();
    check("f8_done", wr_done, 1);
    check("f8_full", bank_full, 2'b01);
    check("f8_wr_en_off", wr_en, 0);
    tick();
    settle();
    check("f8_done_pulse", wr_done, 0);
    tick();

    // Drain bank 0: len 8, 23 cycles
    rd_start = 1'b1;
    settle();
    check("d8_busy_pre", rd_busy, 0);
    tick();
    rd_start = 1'b0;
    for (int t = 0; t < 23; t++) begin
      settle();
      check("d8_en0", rd_en[0], (t < 8) ? 1 : 0);
      check("d8_addr0", rd_addr[0], (t < 8) ? t : 0);
      check("d8_en15", rd_en[15], (t >= 15 && t < 23) ? 1 : 0);
      check("d8_addr15", rd_addr[15], (t >= 15 && t < 23) ? t - 15 : 0);
      check("d8_done", rd_done, (t == 22) ? 1 : 0);
      check("d8_busy", rd_busy, 1);
      tick();
    end
    settle();
    check("d8_full_clr", bank_full, 0);
    check("d8_busy_off", rd_busy, 0);
    tick();

    // Zero-length beat is ignored
    num_row     = 9'd0;
    wr_valid_in = 1'b1;
    settle();
    check("z_ready", wr_ready, 1);
    check("z_wr_en", wr_en, 0);
    tick();
    settle();
    check("z_full", bank_full, 0);
    check("z_done", wr_done, 0);
    tick();

    // Two fills, then a third beat stalls until the first drain ends
    apply_reset();
    num_row     = 9'd2;
    wr_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bb0_addr", wr_addr[0], i);
      tick();
    end
    num_row = 9'd3;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bb1_ready", wr_ready, 1);
      check("bb1_addr", wr_addr[0], 256 + i);
      tick();
    end
    num_row  = 9'd4;
    rd_start = 1'b1;
    settle();
    check("bb_stall_ready", wr_ready, 0);
    check("bb_stall_en", wr_en, 0);
    check("bb_full", bank_full, 2'b11);
    tick();
    rd_start = 1'b0;
    for (int t = 0; t < 17; t++) begin
      settle();
      check("bb_drain_ready", wr_ready, 0);
      check("bb_drain_done", rd_done, (t == 16) ? 1 : 0);
      tick();
    end

    // Freed bank 0 refills while bank 1 drains
    rd_start = 1'b1;
    settle();
    check("ov_ready", wr_ready, 1);
    check("ov_wr_en", wr_en, 32'hffff);
    check("ov_addr_first", wr_addr[0], 0);
    check("ov_full", bank_full, 2'b10);
    check("ov_busy_pre", rd_busy, 0);
    tick();
    rd_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      check("ov_ready_run", wr_ready, 1);
      check("ov_waddr", wr_addr[0], i);
      check("ov_en0", rd_en[0], 1);
      check("ov_raddr0", rd_addr[0], 256 + (i - 1));
      check("ov_en1", rd_en[1], (i - 1 >= 1) ? 1 : 0);
      check("ov_raddr1", rd_addr[1], (i - 1 >= 1) ? 256 + i - 2 : 0);
      tick();
    end
    wr_valid_in = 1'b0;
    settle();
    check("ov_wdone", wr_done, 1);
    check("ov_full2", bank_full, 2'b11);
    check("ov_en0_end", rd_en[0], 0);
    check("ov_en1_t3", rd_en[1], 1);
    check("ov_raddr1_t3", rd_addr[1], 258);
    tick();
    for (int t = 4; t < 18; t++) begin
      settle();
      check("ov_rd_done", rd_done, (t == 17) ? 1 : 0);
      tick();
    end
    settle();
    check("ov_full_end", bank_full, 2'b01);
    check("ov_busy_end", rd_busy, 0);
    tick();

    // Oversized tile clamps to DEPTH
    apply_reset();
    num_row     = 9'd300;
    wr_valid_in = 1'b1;
    for (int i = 0; i < 256; i++) begin
      settle();
      check("cl_ready", wr_ready, 1);
      check("cl_addr", wr_addr[0], i);
      check("cl_done_lo", wr_done, 0);
      tick();
    end
    wr_valid_in = 1'b0;
    settle();
    check("cl_done", wr_done, 1);
    check("cl_full", bank_full, 2'b01);
    tick();

    // Reset during beat 4 of a fill
    apply_reset();
    num_row     = 9'd8;
    wr_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("mr_addr", wr_addr[0], i);
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    check("mr_wr_en", wr_en, 0);
    check("mr_addr_rst", wr_addr[0], 0);
    check("mr_ready", wr_ready, 1);
    check("mr_full", bank_full, 0);
    check("mr_done", wr_done, 0);
    check("mr_busy", rd_busy, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    settle();
    check("mr_restart_en", wr_en, 32'hffff);
    check("mr_restart_addr", wr_addr[0], 0);
    tick();
    wr_valid_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
